// File: rtl/hdlc_tx_sequencer.sv
// Frame-level HDLC transmit sequencer: idle fill, start flag, buffered data,
// two FCS bytes, end flag, with abort handling and FCS generator control.
module hdlc_tx_sequencer #(
   parameter int unsigned MAX_BYTES  = 126,
   parameter logic [7:0]  FLAG_BYTE  = 8'h7E,
   parameter logic [7:0]  ABORT_BYTE = 8'hFE,
   parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Tx_Enable,
   input  logic        Tx_AbortFrame,
   input  logic [7:0]  Tx_FrameSize,
   output logic        Tx_RdBuff,
   input  logic [7:0]  Tx_DataOutBuff,
   output logic        Fcs_Clear,
   output logic        Fcs_Update,
   input  logic [15:0] Fcs_Value,
   output logic [7:0]  Ser_Byte,
   output logic [1:0]  Ser_Kind,
   output logic        Ser_Valid,
   input  logic        Ser_Ready,
   output logic        Tx_ValidFrame,
   output logic        Tx_Done,
   output logic        Tx_AbortedTrans
);

   localparam logic [1:0] KIND_DATA  = 2'd0;
   localparam logic [1:0] KIND_FLAG  = 2'd1;
   localparam logic [1:0] KIND_ABORT = 2'd2;
   localparam logic [1:0] KIND_IDLE  = 2'd3;
   localparam logic [7:0] MAX_SIZE   = 8'(MAX_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_FCS_LO, S_FCS_HI, S_END, S_ABORT
   } state_t;

   state_t      state_q, state_d;
   logic        ser_valid_q, ser_valid_d;
   logic [7:0]  ser_byte_q, ser_byte_d;
   logic [1:0]  ser_kind_q, ser_kind_d;
   logic        rd_start_q, rd_start_d;
   logic        fcs_clear_q, fcs_clear_d;
   logic        load_q, load_d;
   logic        valid_frame_q, valid_frame_d;
   logic        done_q, done_d;
   logic        aborted_q, aborted_d;
   logic        pending_q, pending_d;
   logic        abort_q, abort_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  size_q, size_d;
   logic [7:0]  hold_q, hold_d;

   logic        hs, abort_now, more, rd_data, go_abort, size_ok;
   logic [7:0]  cnt_inc;

   always_comb begin
      hs        = ser_valid_q & Ser_Ready;
      abort_now = abort_q | Tx_AbortFrame;
      cnt_inc   = cnt_q + 8'd1;
      more      = cnt_inc < size_q;
      size_ok   = (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= MAX_SIZE);
      rd_data   = (state_q == S_DATA) && hs && more && !abort_now;
      go_abort  = 1'b0;

      state_d       = state_q;
      ser_valid_d   = ser_valid_q;
      ser_byte_d    = ser_byte_q;
      ser_kind_d    = ser_kind_q;
      rd_start_d    = 1'b0;
      fcs_clear_d   = 1'b0;
      load_d        = rd_start_q | rd_data;
      valid_frame_d = valid_frame_q;
      done_d        = done_q;
      aborted_d     = aborted_q;
      pending_d     = pending_q;
      abort_d       = abort_q;
      cnt_d         = cnt_q;
      size_d        = size_q;
      // Read data is valid exactly one cycle after the strobe; keep a copy
      // so a late start-flag handshake can still find the first byte.
      hold_d        = load_q ? Tx_DataOutBuff : hold_q;

      if (state_q != S_IDLE && state_q != S_ABORT) abort_d = abort_now;

      case (state_q)
         S_IDLE: begin
            ser_valid_d = 1'b1;
            ser_byte_d  = IDLE_BYTE;
            ser_kind_d  = KIND_IDLE;
            if (Tx_AbortFrame) begin
               pending_d = 1'b0;
               done_d    = 1'b1;
            end else if (Tx_Enable && size_ok) begin
               pending_d = 1'b1;
               size_d    = Tx_FrameSize;
               done_d    = 1'b0;
            end
            if (hs && pending_q && !Tx_AbortFrame) begin
               state_d       = S_START;
               ser_byte_d    = FLAG_BYTE;
               ser_kind_d    = KIND_FLAG;
               fcs_clear_d   = 1'b1;
               rd_start_d    = 1'b1;
               valid_frame_d = 1'b1;
               aborted_d     = 1'b0;
               pending_d     = 1'b0;
               abort_d       = 1'b0;
               cnt_d         = 8'd0;
            end
         end
         S_START: begin
            if (hs) begin
               if (abort_now) go_abort = 1'b1;
               else begin
                  state_d    = S_DATA;
                  ser_kind_d = KIND_DATA;
                  // First byte not back from the buffer yet: wait in DATA.
                  ser_valid_d = !rd_start_q;
                  ser_byte_d  = load_q ? Tx_DataOutBuff : hold_q;
               end
            end
         end
         S_DATA: begin
            if (!ser_valid_q) begin
               if (abort_now) go_abort = 1'b1;
               else if (load_q) begin
                  ser_byte_d  = Tx_DataOutBuff;
                  ser_valid_d = 1'b1;
               end
            end else if (hs) begin
               cnt_d = cnt_inc;
               if (abort_now) go_abort = 1'b1;
               else begin
                  ser_valid_d = 1'b0;
                  if (!more) state_d = S_FCS_LO;
               end
            end
         end
         S_FCS_LO: begin
            // The gap cycle lets the generator fold in the last data byte.
            if (!ser_valid_q) begin
               if (abort_now) go_abort = 1'b1;
               else begin
                  ser_byte_d  = Fcs_Value[7:0];
                  ser_kind_d  = KIND_DATA;
                  ser_valid_d = 1'b1;
               end
            end else if (hs) begin
               if (abort_now) go_abort = 1'b1;
               else begin
                  state_d    = S_FCS_HI;
                  ser_byte_d = Fcs_Value[15:8];
               end
            end
         end
         S_FCS_HI: begin
            if (hs) begin
               if (abort_now) go_abort = 1'b1;
               else begin
                  state_d    = S_END;
                  ser_byte_d = FLAG_BYTE;
                  ser_kind_d = KIND_FLAG;
               end
            end
         end
         S_END: begin
            if (hs) begin
               if (abort_now) go_abort = 1'b1;
               else begin
                  state_d       = S_IDLE;
                  ser_byte_d    = IDLE_BYTE;
                  ser_kind_d    = KIND_IDLE;
                  valid_frame_d = 1'b0;
                  done_d        = 1'b1;
                  abort_d       = 1'b0;
               end
            end
         end
         S_ABORT: begin
            if (hs) begin
               state_d       = S_IDLE;
               ser_byte_d    = IDLE_BYTE;
               ser_kind_d    = KIND_IDLE;
               valid_frame_d = 1'b0;
               done_d        = 1'b1;
               aborted_d     = 1'b1;
               abort_d       = 1'b0;
               pending_d     = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (go_abort) begin
         state_d     = S_ABORT;
         ser_byte_d  = ABORT_BYTE;
         ser_kind_d  = KIND_ABORT;
         ser_valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q       <= S_IDLE;
         ser_valid_q   <= 1'b0;
         ser_byte_q    <= IDLE_BYTE;
         ser_kind_q    <= KIND_IDLE;
         rd_start_q    <= 1'b0;
         fcs_clear_q   <= 1'b0;
         load_q        <= 1'b0;
         valid_frame_q <= 1'b0;
         done_q        <= 1'b1;
         aborted_q     <= 1'b0;
         pending_q     <= 1'b0;
         abort_q       <= 1'b0;
         cnt_q         <= 8'd0;
         size_q        <= 8'd0;
      end else begin
         state_q       <= state_d;
         ser_valid_q   <= ser_valid_d;
         ser_byte_q    <= ser_byte_d;
         ser_kind_q    <= ser_kind_d;
         rd_start_q    <= rd_start_d;
         fcs_clear_q   <= fcs_clear_d;
         load_q        <= load_d;
         valid_frame_q <= valid_frame_d;
         done_q        <= done_d;
         aborted_q     <= aborted_d;
         pending_q     <= pending_d;
         abort_q       <= abort_d;
         cnt_q         <= cnt_d;
         size_q        <= size_d;
      end
   end

   always_ff @(posedge Clk) begin
      hold_q <= hold_d;
   end

   assign Tx_RdBuff       = rd_start_q | rd_data;
   assign Fcs_Update      = (state_q == S_DATA) && hs;
   assign Fcs_Clear       = fcs_clear_q;
   assign Ser_Byte        = ser_byte_q;
   assign Ser_Kind        = ser_kind_q;
   assign Ser_Valid       = ser_valid_q;
   assign Tx_ValidFrame   = valid_frame_q;
   assign Tx_Done         = done_q;
   assign Tx_AbortedTrans = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// Directed bench for hdlc_tx_sequencer with buffer, FCS generator and
// serializer-side monitor models.
module tb_hdlc_tx_sequencer;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Tx_Enable, Tx_AbortFrame;
   logic [7:0]  Tx_FrameSize;
   logic        Tx_RdBuff;
   logic [7:0]  Tx_DataOutBuff;
   logic        Fcs_Clear, Fcs_Update;
   logic [15:0] Fcs_Value;
   logic [7:0]  Ser_Byte;
   logic [1:0]  Ser_Kind;
   logic        Ser_Valid, Ser_Ready;
   logic        Tx_ValidFrame, Tx_Done, Tx_AbortedTrans;

   hdlc_tx_sequencer dut (
      .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
      .Tx_FrameSize(Tx_FrameSize), .Tx_RdBuff(Tx_RdBuff), .Tx_DataOutBuff(Tx_DataOutBuff),
      .Fcs_Clear(Fcs_Clear), .Fcs_Update(Fcs_Update), .Fcs_Value(Fcs_Value),
      .Ser_Byte(Ser_Byte), .Ser_Kind(Ser_Kind), .Ser_Valid(Ser_Valid), .Ser_Ready(Ser_Ready),
      .Tx_ValidFrame(Tx_ValidFrame), .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] fcs_step(input logic [15:0] f, input logic [7:0] b);
      return {f[7:0] ^ {b[0], b[7:1]}, f[15:8] ^ b};
   endfunction

   // Buffer model: byte n of every frame (1-based) holds the value n.
   logic       buf_rst;
   logic [7:0] rd_ptr;
   always @(posedge Clk) begin
      if (buf_rst) rd_ptr <= 8'd0;
      else if (Tx_RdBuff) begin
         Tx_DataOutBuff <= rd_ptr + 8'd1;
         rd_ptr         <= rd_ptr + 8'd1;
      end
   end

   always @(posedge Clk) begin
      if (Fcs_Clear) Fcs_Value <= 16'hFFFF;
      else if (Fcs_Update) Fcs_Value <= fcs_step(Fcs_Value, Ser_Byte);
   end

   int         rd_cnt = 0, upd_cnt = 0, stall_err = 0;
   logic       stall_q = 1'b0;
   logic [7:0] stall_byte;
   logic [1:0] stall_kind;
   logic [9:0] hs_log[$];

   always @(negedge Clk) begin
      if (Rst) stall_q <= 1'b0;
      else begin
         if (Tx_RdBuff) rd_cnt <= rd_cnt + 1;
         if (Fcs_Update) upd_cnt <= upd_cnt + 1;
         if (stall_q && (!Ser_Valid || Ser_Byte != stall_byte || Ser_Kind != stall_kind))
            stall_err <= stall_err + 1;
         stall_q    <= Ser_Valid && !Ser_Ready;
         stall_byte <= Ser_Byte;
         stall_kind <= Ser_Kind;
         if (Ser_Valid && Ser_Ready) hs_log.push_back({Ser_Kind, Ser_Byte});
      end
   end

   int n_asserts = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic start_frame(input logic [7:0] size);
      Tx_FrameSize = size;
      Tx_Enable    = 1'b1;
      tick(1);
      Tx_Enable    = 1'b0;
   endtask

   function automatic int find_flag(input int n0);
      for (int i = n0; i < hs_log.size(); i++)
         if (hs_log[i][9:8] != 2'd3) return i;
      return -1;
   endfunction

   task automatic wait_updates(input int base, input int n, input string tag);
      for (int i = 0; i < 500 && (upd_cnt - base) < n; i++) tick(1);
      chk(tag, upd_cnt - base, n);
   endtask

   task automatic check_frame(input int n0, input int size, input string tag);
      int idx, bad;
      logic [15:0] e;
      idx = find_flag(n0);
      chk({tag, "_found"}, idx >= 0, 1);
      if (idx < 0) return;
      if (idx + size + 4 >= hs_log.size()) begin
         chk({tag, "_len"}, hs_log.size(), idx + size + 5);
         return;
      end
      chk({tag, "_start_flag"}, hs_log[idx], {2'd1, 8'h7E});
      e = 16'hFFFF;
      bad = 0;
      for (int i = 0; i < size; i++) begin
         if (hs_log[idx + 1 + i] !== {2'd0, 8'(i + 1)}) bad++;
         e = fcs_step(e, 8'(i + 1));
      end
      chk({tag, "_data_errors"}, bad, 0);
      chk({tag, "_fcs_lo"}, hs_log[idx + size + 1], {2'd0, e[7:0]});
      chk({tag, "_fcs_hi"}, hs_log[idx + size + 2], {2'd0, e[15:8]});
      chk({tag, "_end_flag"}, hs_log[idx + size + 3], {2'd1, 8'h7E});
      chk({tag, "_idle_after"}, hs_log[idx + size + 4], {2'd3, 8'hFF});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, r0, u0, idx, seen, fin, ab_start;
      Rst = 1'b1; buf_rst = 1'b1;
      Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_FrameSize = 8'd0; Ser_Ready = 1'b0;
      tick(2);
      chk("rst_ser_valid", Ser_Valid, 0);
      chk("rst_ser_byte", Ser_Byte, 8'hFF);
      chk("rst_ser_kind", Ser_Kind, 3);
      chk("rst_rdbuff", Tx_RdBuff, 0);
      chk("rst_fcs_strobes", {Fcs_Clear, Fcs_Update}, 0);
      chk("rst_status", {Tx_ValidFrame, Tx_Done, Tx_AbortedTrans}, 3'b010);
      Rst = 1'b0; buf_rst = 1'b0; Ser_Ready = 1'b1;
      tick(3);
      chk("idle_offer", {Ser_Valid, Ser_Kind, Ser_Byte}, {1'b1, 2'd3, 8'hFF});

      // Normal 3-byte frame
      n0 = hs_log.size(); r0 = rd_cnt; u0 = upd_cnt;
      start_frame(8'd3);
      chk("f3_done_low", Tx_Done, 0);
      tick(2);
      chk("f3_valid_frame", Tx_ValidFrame, 1);
      tick(30);
      check_frame(n0, 3, "f3");
      chk("f3_rd_pulses", rd_cnt - r0, 3);
      chk("f3_upd_pulses", upd_cnt - u0, 3);
      chk("f3_end_status", {Tx_ValidFrame, Tx_Done}, 2'b01);

      // Out-of-range sizes are ignored
      n0 = hs_log.size(); r0 = rd_cnt;
      start_frame(8'd0);
      chk("sz0_done", Tx_Done, 1);
      tick(5);
      chk("sz0_kind", Ser_Kind, 3);
      start_frame(8'd127);
      chk("sz127_done", Tx_Done, 1);
      tick(5);
      chk("sz127_kind", Ser_Kind, 3);
      chk("bad_size_no_frame", find_flag(n0), -1);
      chk("bad_size_no_rd", rd_cnt - r0, 0);

      // Abort while byte 5 of 10 is stalled
      buf_rst = 1'b1; tick(1); buf_rst = 1'b0;
      n0 = hs_log.size(); r0 = rd_cnt; u0 = upd_cnt;
      start_frame(8'd10);
      wait_updates(u0, 4, "ab_four_bytes");
      Ser_Ready = 1'b0;
      tick(1);
      chk("ab_b5_offered", {Ser_Valid, Ser_Kind, Ser_Byte}, {1'b1, 2'd0, 8'd5});
      Tx_AbortFrame = 1'b1;
      tick(1);
      Tx_AbortFrame = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("ab_b5_stable", {Ser_Valid, Ser_Byte}, {1'b1, 8'd5});
         tick(1);
      end
      Ser_Ready = 1'b1;
      tick(10);
      idx = find_flag(n0);
      chk("ab_found", idx >= 0 && idx + 7 < hs_log.size(), 1);
      if (idx >= 0 && idx + 7 < hs_log.size()) begin
         chk("ab_byte5", hs_log[idx + 5], {2'd0, 8'd5});
         chk("ab_abort_byte", hs_log[idx + 6], {2'd2, 8'hFE});
         chk("ab_idle_after", hs_log[idx + 7], {2'd3, 8'hFF});
      end
      chk("ab_rd_pulses", rd_cnt - r0, 5);
      chk("ab_upd_pulses", upd_cnt - u0, 5);
      chk("ab_status", {Tx_ValidFrame, Tx_Done, Tx_AbortedTrans}, 3'b011);

      // Maximum frame with random serializer back-pressure
      buf_rst = 1'b1; tick(1); buf_rst = 1'b0;
      n0 = hs_log.size(); r0 = rd_cnt; u0 = upd_cnt;
      start_frame(8'd126);
      seen = 0; fin = 0; ab_start = 1;
      for (int i = 0; i < 6000; i++) begin
         Ser_Ready = 1'($urandom_range(0, 1));
         tick(1);
         if (Tx_ValidFrame && !seen) begin
            seen = 1;
            ab_start = Tx_AbortedTrans;
         end
         if (seen && !Tx_ValidFrame) begin
            fin = 1;
            break;
         end
      end
      Ser_Ready = 1'b1;
      chk("f126_finished", fin, 1);
      chk("f126_aborted_cleared", ab_start, 0);
      tick(3);
      check_frame(n0, 126, "f126");
      chk("f126_rd_pulses", rd_cnt - r0, 126);
      chk("f126_upd_pulses", upd_cnt - u0, 126);
      chk("stall_stability_errors", stall_err, 0);

      // Asynchronous reset in mid-frame
      buf_rst = 1'b1; tick(1); buf_rst = 1'b0;
      u0 = upd_cnt;
      start_frame(8'd5);
      wait_updates(u0, 2, "rst_two_bytes");
      Rst = 1'b1;
      #1;
      chk("midrst_outputs", {Tx_ValidFrame, Tx_Done, Ser_Valid}, 3'b010);
      buf_rst = 1'b1;
      tick(1);
      Rst = 1'b0; buf_rst = 1'b0;
      tick(2);
      chk("postrst_idle", {Ser_Valid, Ser_Kind, Ser_Byte}, {1'b1, 2'd3, 8'hFF});
      n0 = hs_log.size();
      start_frame(8'd1);
      tick(20);
      check_frame(n0, 1, "f1");

      // Enable together with abort in IDLE
      n0 = hs_log.size(); r0 = rd_cnt;
      Tx_FrameSize = 8'd3; Tx_Enable = 1'b1; Tx_AbortFrame = 1'b1;
      tick(1);
      Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0;
      chk("enab_done", Tx_Done, 1);
      tick(10);
      chk("enab_no_frame", find_flag(n0), -1);
      chk("enab_no_rd", rd_cnt - r0, 0);

      // Enable during DATA is ignored
      buf_rst = 1'b1; tick(1); buf_rst = 1'b0;
      n0 = hs_log.size(); u0 = upd_cnt;
      start_frame(8'd3);
      wait_updates(u0, 1, "mid_en_one_byte");
      start_frame(8'd10);
      tick(30);
      check_frame(n0, 3, "mid_en");
      chk("mid_en_upd_pulses", upd_cnt - u0, 3);
      chk("mid_en_done", Tx_Done, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/hdlc_tx_sequencer.md
Name: hdlc_tx_sequencer

Overview:
- Frame-level controller for the HDLC transmit path.
- Sits between the Tx buffer (byte storage plus frame size) and the bit-level serializer, which handles zero insertion and shifting.
- Sequences each frame as: idle pattern → start flag → buffered data bytes → 2 FCS bytes → end flag → idle.
- Handles abort, drives Tx status bits, and controls the FCS generator.

Parameters:
MAX_BYTES, 126, largest accepted Tx_FrameSize
FLAG_BYTE, 8'h7E, start/end flag
ABORT_BYTE, 8'hFE, abort pattern (LSB first: 0 then seven 1s)
IDLE_BYTE, 8'hFF, idle pattern

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous active-high reset
Tx_Enable  in  1  one-cycle start request
Tx_AbortFrame  in  1  one-cycle abort request
Tx_FrameSize  in  8  bytes held in Tx buffer
Tx_RdBuff  out  1  buffer read strobe; data valid on Tx_DataOutBuff the next cycle
Tx_DataOutBuff  in  8  buffer read data
Fcs_Clear  out  1  one-cycle pulse, clear FCS generator
Fcs_Update  out  1  one-cycle pulse, fold Ser_Byte into FCS (on data handshake)
Fcs_Value  in  16  current FCS from generator
Ser_Byte  out  8  byte to serializer
Ser_Kind  out  2  0 = data (zero insertion on), 1 = flag, 2 = abort, 3 = idle
Ser_Valid  out  1  byte offered
Ser_Ready  in  1  serializer accepts; handshake = Ser_Valid & Ser_Ready
Tx_ValidFrame  out  1  frame in progress
Tx_Done  out  1  buffer consumed, sequencer idle
Tx_AbortedTrans  out  1  last frame aborted (sticky)

Behaviour:
- Reset values:
  - State IDLE.
  - Ser_Valid=0, Ser_Byte=IDLE_BYTE, Ser_Kind=3.
  - Tx_RdBuff=0, Fcs_Clear=0, Fcs_Update=0.
  - Tx_ValidFrame=0, Tx_Done=1, Tx_AbortedTrans=0.
  - Byte counter 0, pending-start 0.
- Handshake rules:
  - Ser_Byte/Ser_Kind change only in the cycle after a handshake, or when Ser_Valid is 0.
  - Once raised, Ser_Valid stays high until a handshake.
- States and transitions:
  - IDLE:
    - Ser_Valid=1 with IDLE_BYTE, kind 3, continuously.
    - Tx_Enable with 1 ≤ Tx_FrameSize ≤ MAX_BYTES latches pending-start, latches the size, and drops Tx_Done the next cycle.
    - Tx_Enable with any other size is ignored; Tx_Done stays 1.
    - On the next idle handshake with pending set → START.
  - START:
    - Fcs_Clear pulses on entry; Tx_ValidFrame=1; Tx_AbortedTrans clears.
    - Offers FLAG_BYTE, kind 1.
    - Tx_RdBuff pulses on entry, so the first data byte is prefetched into the holding register.
    - Handshake → DATA.
  - DATA:
    - Offers the holding register, kind 0.
    - On handshake: Fcs_Update pulses and the counter increments.
    - If counter < size: Tx_RdBuff pulses the same cycle and the new byte is offered the cycle after read data returns. Ser_Valid=0 during that one-cycle gap.
    - When counter == size → FCS_LO.
  - FCS_LO: offers Fcs_Value[7:0], kind 0, no Fcs_Update; handshake → FCS_HI.
  - FCS_HI: offers Fcs_Value[15:8], kind 0; handshake → END.
  - END: offers FLAG_BYTE, kind 1; handshake → IDLE with Tx_ValidFrame=0 and Tx_Done=1 the next cycle.
  - ABORT: offers ABORT_BYTE, kind 2; handshake → IDLE, Tx_ValidFrame=0, Tx_Done=1, Tx_AbortedTrans=1.
- Abort:
  - Tx_AbortFrame in START, DATA, FCS_LO, FCS_HI or END is latched.
  - The byte currently offered completes its handshake (never truncated); the next state is then ABORT instead of the normal successor.
  - No further Tx_RdBuff after the abort is latched.
  - Abort in IDLE clears pending-start; with no pending it has no effect.
  - Tx_Enable and Tx_AbortFrame in the same IDLE cycle: abort wins, no frame starts, Tx_Done stays 1.
- Tx_Enable while not IDLE is ignored.
- Counter and latched size are 8-bit; size is never re-sampled mid-frame.
- Asynchronous Rst mid-frame returns all outputs to reset values immediately; the serializer flushes independently.
- Sustained Ser_Ready=1 gives one byte per handshake. The serializer throttles to ≥8 cycles per byte (more with zero insertion).

Test Plan:
- Size 3 buffer {8'h01,8'h02,8'h03}, Tx_Enable, Ser_Ready=1 → handshake byte/kind order: 7E/1, 01/0, 02/0, 03/0, FCS lo/0, FCS hi/0, 7E/1, then FF/3; exactly 3 Tx_RdBuff and 3 Fcs_Update pulses; Tx_ValidFrame high from START to END handshake; Tx_Done 0 then 1.
- Tx_Enable with Tx_FrameSize=0 and with 127 → no state change, Ser_Kind stays 3, Tx_Done stays 1, no Tx_RdBuff.
- Size 10, Tx_AbortFrame pulsed after the 4th data handshake while the 5th byte is offered with Ser_Ready held low 5 cycles → 5th byte stays stable and completes, then FE/kind 2, then idle; Tx_AbortedTrans=1, exactly 5 Tx_RdBuff pulses; the next Tx_Enable clears Tx_AbortedTrans.
- Size 126 with Ser_Ready randomly toggled → 126 data handshakes, Ser_Byte never changes while Valid & !Ready, counter reaches 126 without wrap.
- Rst asserted during DATA (size 5, after byte 2) → same-cycle Tx_ValidFrame=0, Tx_Done=1, Ser_Valid=0; after release, idle FF/3 resumes and a fresh size-1 frame completes normally.
- Tx_Enable and Tx_AbortFrame in the same IDLE cycle → no frame; Tx_Enable in DATA → ignored, frame length unchanged.
